// File: rtl/fsm_rule_ctrl.sv
// rtl/fsm_rule_ctrl.sv - table-driven Mealy controller with prioritised per-state match rules
module fsm_rule_ctrl #(
  parameter int NX        = 5,
  parameter int NY        = 25,
  parameter int NS        = 32,
  parameter int NR        = 8,
  parameter int CW        = 16,
  parameter int RST_STATE = 1,
  localparam int SW       = $clog2(NS),
  localparam int RW       = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [NX-1:0] x,
  input  logic [SW-1:0] num_states,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_state,
  input  logic [RW-1:0] cfg_rule,
  input  logic          cfg_valid,
  input  logic [NX-1:0] cfg_mask,
  input  logic [NX-1:0] cfg_val,
  input  logic [SW-1:0] cfg_next,
  input  logic [NY-1:0] cfg_out,
  input  logic          clr,
  output logic [NY-1:0] y,
  output logic [SW-1:0] state,
  output logic [CW-1:0] step_cnt,
  output logic          nomatch,
  output logic          err
);

  localparam logic [SW-1:0] RST_ST = SW'(RST_STATE);
  localparam int NE = NS * NR;

  // Rule table: entry address is {state, rule}
  logic [NE-1:0] tbl_valid;
  logic [NX-1:0] tbl_mask [NE];
  logic [NX-1:0] tbl_val  [NE];
  logic [SW-1:0] tbl_next [NE];
  logic [NY-1:0] tbl_out  [NE];

  logic [SW+RW-1:0] waddr;
  logic             wr_en;
  logic             hit;
  logic [RW-1:0]    hit_idx;
  logic [SW+RW-1:0] raddr;
  logic             illegal;
  logic             take;
  logic [SW-1:0]    state_nxt;
  logic [NY-1:0]    y_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             nomatch_nxt;
  logic             err_nxt;

  // Writes only land while the controller is stopped
  assign wr_en = cfg_we && !run;
  assign waddr = {cfg_state, cfg_rule};

  // Valid bits are reset so a fresh table starts empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tbl_valid <= '0;
    else if (wr_en) tbl_valid[waddr] <= cfg_valid;
  end

  // Rule payload fields carry no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_mask[waddr] <= cfg_mask;
      tbl_val[waddr]  <= cfg_val;
      tbl_next[waddr] <= cfg_next;
      tbl_out[waddr]  <= cfg_out;
    end
  end

  // Priority match over the current state's rules, lowest index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int r = NR - 1; r >= 0; r--) begin
      if (tbl_valid[{state, RW'(r)}] &&
          (((x ^ tbl_val[{state, RW'(r)}]) & tbl_mask[{state, RW'(r)}]) == '0)) begin
        hit     = 1'b1;
        hit_idx = RW'(r);
      end
    end
  end

  assign raddr   = {state, hit_idx};
  assign illegal = run && (state > num_states);
  assign take    = run && !illegal && hit;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_ST;
      y        <= '0;
      step_cnt <= '0;
      nomatch  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      y        <= y_nxt;
      step_cnt <= cnt_nxt;
      nomatch  <= nomatch_nxt;
      err      <= err_nxt;
    end
  end

  // Next-state selection: recovery, taken rule, or hold
  always_comb begin
    state_nxt = state;
    if (illegal)   state_nxt = RST_ST;
    else if (take) state_nxt = tbl_next[raddr];
  end

  // Output and status next values; clear loses to a fresh illegal-state detection
  always_comb begin
    y_nxt       = take ? tbl_out[raddr] : '0;
    nomatch_nxt = run && !illegal && !hit;
    cnt_nxt     = step_cnt;
    if (take && (step_cnt != '1)) cnt_nxt = step_cnt + 1'b1;
    if (clr) cnt_nxt = '0;
    err_nxt = err;
    if (clr)     err_nxt = 1'b0;
    if (illegal) err_nxt = 1'b1;
  end

endmodule

// File: tb/tb_fsm_rule_ctrl.sv
// tb/tb_fsm_rule_ctrl.sv - randomized scoreboard bench for fsm_rule_ctrl
module tb_fsm_rule_ctrl;

  localparam int NX = 5, NY = 25, NS = 32, NR = 8, CW = 4;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          run = 0;
  logic [NX-1:0] x = '0;
  logic [4:0]    num_states = 5'd31;
  logic          cfg_we = 0;
  logic [4:0]    cfg_state = '0;
  logic [2:0]    cfg_rule = '0;
  logic          cfg_valid = 0;
  logic [NX-1:0] cfg_mask = '0;
  logic [NX-1:0] cfg_val = '0;
  logic [4:0]    cfg_next = '0;
  logic [NY-1:0] cfg_out = '0;
  logic          clr = 0;
  logic [NY-1:0] y;
  logic [4:0]    state;
  logic [CW-1:0] step_cnt;
  logic          nomatch;
  logic          err;

  fsm_rule_ctrl #(.NX(NX), .NY(NY), .NS(NS), .NR(NR), .CW(CW), .RST_STATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .x(x), .num_states(num_states),
    .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_rule(cfg_rule), .cfg_valid(cfg_valid),
    .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_next(cfg_next), .cfg_out(cfg_out),
    .clr(clr), .y(y), .state(state), .step_cnt(step_cnt), .nomatch(nomatch), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NY-1:0] y;
    logic [4:0]    st;
    logic [CW-1:0] cnt;
    logic          nm;
    logic          er;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: rule table as plain arrays, behaviour as ordered rules
  bit            m_v   [32][8];
  logic [NX-1:0] m_msk [32][8];
  logic [NX-1:0] m_val [32][8];
  logic [4:0]    m_nxt [32][8];
  logic [NY-1:0] m_out [32][8];
  int            m_state;
  int            m_cnt;
  logic [NY-1:0] m_y;
  bit            m_nm, m_err;

  task automatic model_reset();
    for (int s = 0; s < 32; s++)
      for (int r = 0; r < 8; r++) m_v[s][r] = 0;
    m_state = 1; m_cnt = 0; m_y = '0; m_nm = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit bad;
    int hit_r;
    exp_t e;
    bad = run && (m_state > int'(num_states));
    if (run) begin
      if (bad) begin
        m_state = 1; m_y = '0; m_err = 1; m_nm = 0;
      end else begin
        hit_r = -1;
        for (int r = 0; r < 8; r++)
          if (hit_r < 0 && m_v[m_state][r] && (((x ^ m_val[m_state][r]) & m_msk[m_state][r]) == 0))
            hit_r = r;
        if (hit_r >= 0) begin
          m_y = m_out[m_state][hit_r];
          m_state = int'(m_nxt[m_state][hit_r]);
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          m_nm = 0;
        end else begin
          m_y = '0; m_nm = 1;
        end
      end
    end else begin
      m_y = '0; m_nm = 0;
      if (cfg_we) begin
        m_v[cfg_state][cfg_rule]   = cfg_valid;
        m_msk[cfg_state][cfg_rule] = cfg_mask;
        m_val[cfg_state][cfg_rule] = cfg_val;
        m_nxt[cfg_state][cfg_rule] = cfg_next;
        m_out[cfg_state][cfg_rule] = cfg_out;
      end
    end
    if (clr) begin
      m_cnt = 0;
      if (!bad) m_err = 0;
    end
    e.y = m_y; e.st = 5'(m_state); e.cnt = CW'(m_cnt); e.nm = m_nm; e.er = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock edge that the driver issued
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (y !== e.y || state !== e.st || step_cnt !== e.cnt || nomatch !== e.nm || err !== e.er) begin
        miscompares++;
        $display("FAIL step t=%0t got y=%h st=%0d cnt=%0d nm=%b err=%b exp y=%h st=%0d cnt=%0d nm=%b err=%b",
                 $time, y, state, step_cnt, nomatch, err, e.y, e.st, e.cnt, e.nm, e.er);
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int s, input int r, input bit v, input logic [NX-1:0] m,
                    input logic [NX-1:0] vl, input int n, input logic [NY-1:0] o);
    run = 0; cfg_we = 1; cfg_state = 5'(s); cfg_rule = 3'(r); cfg_valid = v;
    cfg_mask = m; cfg_val = vl; cfg_next = 5'(n); cfg_out = o;
    tick();
    cfg_we = 0;
  endtask

  task automatic step(input logic [NX-1:0] xv);
    run = 1; x = xv;
    tick();
  endtask

  task automatic check_reset(input string name);
    vectors++;
    if (y !== '0 || state !== 5'd1 || step_cnt !== '0 || err !== 1'b0 || nomatch !== 1'b0) begin
      miscompares++;
      $display("FAIL %s got y=%h st=%0d cnt=%0d err=%b nm=%b exp y=0 st=1 cnt=0 err=0 nm=0",
               name, y, state, step_cnt, err, nomatch);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_reset("reset_init");
    @(negedge clk);
    rst_n = 1;

    // Priority: state1 -> 2, state2 rule0 masked match, rule1 unconditional
    wr(1, 0, 1, 5'b00000, 5'b00000, 2, 25'h11);
    wr(2, 0, 1, 5'b11000, 5'b11000, 3, 25'h7A);
    wr(2, 1, 1, 5'b00000, 5'b00000, 7, 25'h1234);
    wr(3, 0, 1, 5'b00000, 5'b00000, 2, 25'h22);
    step(5'b00000);
    step(5'b11001);
    step(5'b00000);
    step(5'b01001);

    // Async reset mid-run with y nonzero
    #2 rst_n = 0;
    #1 check_reset("reset_async");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // No-match: walk to state 4 whose only rule needs x[0]=1
    wr(1, 0, 1, 5'b00000, 5'b00000, 7, 25'h33);
    wr(7, 0, 1, 5'b00000, 5'b00000, 4, 25'h44);
    wr(4, 0, 1, 5'b00001, 5'b00001, 9, 25'h55);
    step(5'b00000);
    step(5'b00000);
    step(5'b00000);
    step(5'b00000);

    // Saturation on a self-loop, then clear
    wr(4, 1, 1, 5'b00000, 5'b00000, 5, 25'h66);
    wr(5, 0, 1, 5'b00000, 5'b00000, 5, 25'h1ABCDEF);
    for (int i = 0; i < 20; i++) step(5'(i));
    clr = 1; step(5'b0); clr = 0;
    step(5'b0);

    // Illegal state: next beyond num_states, then recovery and sticky err
    wr(5, 0, 1, 5'b00000, 5'b00000, 25, 25'h77);
    num_states = 5'd18;
    wr(1, 0, 1, 5'b00000, 5'b00000, 1, 25'h88);
    for (int i = 0; i < 5; i++) step(5'b0);
    clr = 1; step(5'b0); clr = 0;
    step(5'b0);

    // Config guard: write during run is dropped, same write stopped is applied
    run = 1; cfg_we = 1; cfg_state = 5'd1; cfg_rule = 3'd0; cfg_valid = 1;
    cfg_mask = '0; cfg_val = '0; cfg_next = 5'd9; cfg_out = 25'h99;
    x = 5'b0; tick(); tick();
    cfg_we = 0;
    wr(1, 0, 1, 5'b00000, 5'b00000, 9, 25'h99);
    step(5'b0);
    step(5'b0);
    num_states = 5'd31;

    // Randomized phase
    for (int i = 0; i < 150; i++)
      wr($urandom_range(0, 31), $urandom_range(0, 7), ($urandom_range(0, 9) != 0),
         5'($urandom & $urandom), 5'($urandom), $urandom_range(0, 31), 25'($urandom));
    for (int i = 0; i < 3000; i++) begin
      int op;
      op = $urandom_range(0, 99);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) num_states = 5'($urandom_range(10, 31));
      if (op < 8) begin
        wr($urandom_range(0, 31), $urandom_range(0, 7), ($urandom_range(0, 9) != 0),
           5'($urandom & $urandom), 5'($urandom), $urandom_range(0, 31), 25'($urandom));
      end else if (op < 12) begin
        run = 0; x = 5'($urandom); tick();
      end else begin
        cfg_we = ($urandom_range(0, 9) == 0);
        cfg_state = 5'($urandom); cfg_rule = 3'($urandom); cfg_valid = 1'($urandom);
        cfg_mask = 5'($urandom); cfg_val = 5'($urandom); cfg_next = 5'($urandom);
        cfg_out = 25'($urandom);
        step(5'($urandom));
        cfg_we = 0;
      end
      clr = 0;
    end

    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
